// File: rtl/n64_pkg.sv
// n64_pkg: shared N64 line timing, reply lengths and read-response state encoding
package n64_pkg;
   localparam int N64_CLK_PER_US = 100;
   localparam int N64_CELL = 4 * N64_CLK_PER_US;
   localparam int N64_ONE_LOW = N64_CLK_PER_US;
   localparam int N64_ZERO_LOW = 3 * N64_CLK_PER_US;
   localparam int N64_STOP_LOW = N64_CLK_PER_US;
   localparam int N64_SAMPLE = (N64_ONE_LOW + N64_ZERO_LOW) / 2;
   localparam int N64_TIMEOUT = 10 * N64_CLK_PER_US;
   localparam int N64_STATUS_BITS = 32;
   localparam int N64_IDENT_BITS = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_FALL,
      ST_LOW,
      ST_WAIT_RISE,
      ST_STOP_FALL,
      ST_STOP_RISE
   } rr_state_t;

   function automatic int n64_scale(input int cycles, input int clk_per_us);
      return cycles * clk_per_us / N64_CLK_PER_US;
   endfunction
endpackage

// File: rtl/n64_line_sync.sv
// n64_line_sync: two-flop synchronizer for the data line with edge detection
module n64_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic data_in,
   output logic s,
   output logic fall,
   output logic rise
);
   logic [1:0] sync_q, sync_d;
   logic s_d_q, s_d_d;

   always_comb begin
      sync_d = {sync_q[0], data_in};
      s_d_d = sync_q[1];
   end

   // the line idles high, so reset to high to avoid a phantom edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
         s_d_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         s_d_q <= s_d_d;
      end
   end

   assign s = sync_q[1];
   assign fall = s_d_q & ~sync_q[1];
   assign rise = ~s_d_q & sync_q[1];
endmodule

// File: rtl/n64_read_response.sv
// n64_read_response: decodes the controller's pulse-width reply into a word
module n64_read_response
   import n64_pkg::*;
#(
   parameter int CLK_PER_US = N64_CLK_PER_US,
   parameter int SAMPLE = n64_scale(N64_SAMPLE, CLK_PER_US),
   parameter int TIMEOUT = n64_scale(N64_TIMEOUT, CLK_PER_US),
   parameter int NUM_BITS = N64_STATUS_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                data_in,
   output logic [NUM_BITS-1:0] response,
   output logic                valid,
   output logic                timeout,
   output logic                busy
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int CW = $clog2(NUM_BITS + 1);

   rr_state_t state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [NUM_BITS-1:0] shift_q, shift_d, response_q, response_d;
   logic valid_q, valid_d, timeout_q, timeout_d;
   logic s, fall, rise;

   n64_line_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .data_in (data_in),
      .s       (s),
      .fall    (fall),
      .rise    (rise)
   );

   always_comb begin
      state_d = state_q;
      timer_d = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      shift_d = shift_q;
      response_d = response_q;
      valid_d = 1'b0;
      timeout_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (en) begin
               state_d = ST_WAIT_FALL;
               bit_cnt_d = '0;
               shift_d = '0;
            end
         end
         ST_WAIT_FALL, ST_STOP_FALL: if (fall) begin
            state_d = (state_q == ST_WAIT_FALL) ? ST_LOW : ST_STOP_RISE;
            timer_d = '0;
         end
         // the timer keeps running from the falling edge through WAIT_RISE
         ST_LOW: if (timer_q == TW'(SAMPLE - 1)) begin
            shift_d = {shift_q[NUM_BITS-2:0], s};
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d = ST_WAIT_RISE;
         end
         ST_WAIT_RISE: if (s) begin
            state_d = (bit_cnt_q == CW'(NUM_BITS)) ? ST_STOP_FALL : ST_WAIT_FALL;
            timer_d = '0;
         end
         ST_STOP_RISE: if (rise) begin
            response_d = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_q != ST_IDLE && state_d == state_q && timer_q == TW'(TIMEOUT - 1)) begin
         timeout_d = 1'b1;
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         bit_cnt_q <= '0;
         shift_q <= '0;
         response_q <= '0;
         valid_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q <= shift_d;
         response_q <= response_d;
         valid_q <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign response = response_q;
   assign valid = valid_q;
   assign timeout = timeout_q;
   assign busy = (state_q != ST_IDLE);
endmodule
